// File: rtl/joint_position_controller.sv
// Bang-bang position controller for one SCARA joint: filters the encoder degree bus and drives
// turn_left/turn_right along the shortest wrapped path, with reversal dead time and stall detection.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | motor off, waiting for enable with the joint away from target
// S_DEAD  | motor off, dead-time down-counter running before driving pending_dir
// S_DRIVE | exactly one motor line high per last_dir, stall counter running
// S_FAULT | stall detected, motor off until fault_clear
module joint_position_controller #(
  parameter int NUM_DEG      = 90,
  parameter int DEADBAND     = 0,
  parameter int DEAD_CYCLES  = 1000,
  parameter int STALL_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] enc_degree,
  input  logic [6:0] target_deg,
  input  logic       target_valid,
  input  logic       enable,
  input  logic       fault_clear,
  output logic       turn_left,
  output logic       turn_right,
  output logic       busy,
  output logic       done,
  output logic       at_target,
  output logic       cmd_error,
  output logic       fault,
  output logic [6:0] cur_deg
);

  localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [6:0]         NUM7       = 7'(NUM_DEG);
  localparam logic [7:0]         NUM8       = 8'(NUM_DEG);
  localparam logic [7:0]         DB8        = 8'(DEADBAND);
  localparam logic [7:0]         HALF8      = 8'(NUM_DEG / 2);
  localparam logic [7:0]         ARRIVE_HI8 = 8'(NUM_DEG - DEADBAND);
  localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DRIVE, S_FAULT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t               state, state_nxt;
  dir_t                 last_dir, dir_nxt;
  dir_t                 pending_dir, pend_nxt;
  dir_t                 want_dir;
  logic [DEAD_W-1:0]    dead_cnt, dead_nxt;
  logic [STALL_W-1:0]   stall_cnt, stall_nxt;
  logic [6:0]           enc_s1, enc_s2;
  logic [6:0]           target;
  logic [7:0]           diff;
  logic                 enc_load, cur_chg, arrived, done_nxt, stall_trip, accept, tgt_ok;

  // Comparing the two synchroniser stages gives the 3-clock bus-to-cur_deg latency while
  // still requiring a value to be seen on two consecutive clocks before it is trusted.
  assign enc_load = (enc_s1 == enc_s2) && (enc_s2 < NUM7);
  assign cur_chg  = enc_load && (enc_s2 != cur_deg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_s1  <= '0;
      enc_s2  <= '0;
      cur_deg <= '0;
    end else begin
      enc_s1 <= enc_degree;
      enc_s2 <= enc_s1;
      if (enc_load) cur_deg <= enc_s2;
    end
  end

  always_comb begin
    diff = ({1'b0, target} >= {1'b0, cur_deg}) ? ({1'b0, target} - {1'b0, cur_deg})
                                               : ({1'b0, target} + NUM8 - {1'b0, cur_deg});
    arrived  = (diff <= DB8) || (diff >= ARRIVE_HI8);
    want_dir = (diff <= HALF8) ? DIR_RIGHT : DIR_LEFT;
  end

  always_comb begin
    state_nxt  = state;
    dir_nxt    = last_dir;
    pend_nxt   = pending_dir;
    dead_nxt   = dead_cnt;
    stall_nxt  = '0;
    done_nxt   = 1'b0;
    stall_trip = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && !arrived) begin
          state_nxt = S_DEAD;
          pend_nxt  = want_dir;
          dead_nxt  = DEAD_LOAD;
        end
      end
      S_DEAD: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (arrived) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (want_dir != pending_dir) begin
          pend_nxt = want_dir;
          dead_nxt = DEAD_LOAD;
        end else if (dead_cnt == '0) begin
          state_nxt = S_DRIVE;
          dir_nxt   = pending_dir;
        end else begin
          dead_nxt = dead_cnt - 1'b1;
        end
      end
      S_DRIVE: begin
        // Arrival outranks a stall timeout landing on the same clock.
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (arrived) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if ((stall_cnt == STALL_LAST) && !cur_chg) begin
          state_nxt  = S_FAULT;
          stall_trip = 1'b1;
        end else if (want_dir != last_dir) begin
          state_nxt = S_DEAD;
          pend_nxt  = want_dir;
          dead_nxt  = DEAD_LOAD;
        end else begin
          stall_nxt = cur_chg ? '0 : stall_cnt + 1'b1;
        end
      end
      S_FAULT: begin
        if (fault_clear) begin
          state_nxt = S_IDLE;
          dir_nxt   = DIR_NONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A command arriving on the clock a stall trips is dropped along with any error report.
  assign accept = (state != S_FAULT) && !stall_trip;
  assign tgt_ok = target_deg < NUM7;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_dir    <= DIR_NONE;
      pending_dir <= DIR_NONE;
      dead_cnt    <= '0;
      stall_cnt   <= '0;
      target      <= '0;
      turn_left   <= 1'b0;
      turn_right  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      at_target   <= 1'b0;
      cmd_error   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_dir    <= dir_nxt;
      pending_dir <= pend_nxt;
      dead_cnt    <= dead_nxt;
      stall_cnt   <= stall_nxt;
      if (target_valid && accept && tgt_ok) target <= target_deg;
      cmd_error   <= target_valid && accept && !tgt_ok;
      turn_left   <= (state_nxt == S_DRIVE) && (dir_nxt == DIR_LEFT);
      turn_right  <= (state_nxt == S_DRIVE) && (dir_nxt == DIR_RIGHT);
      busy        <= (state_nxt == S_DEAD) || (state_nxt == S_DRIVE);
      fault       <= (state_nxt == S_FAULT);
      done        <= done_nxt;
      at_target   <= arrived;
    end
  end

endmodule

// File: doc/joint_position_controller.md
Name: joint_position_controller

Overview:
- Closed-loop bang-bang position controller for one SCARA joint.
- Takes the encoder decoder's 7-bit degree output (0..89, wraps) and a commanded target angle.
- Drives the motor driver's turn-left / turn-right lines along the shortest path until the joint is at the target.
- Enforces direction-reversal dead time and stall detection; sits between the command source and the motor GPIO.

Parameters:
- NUM_DEG, 90, number of degree positions per revolution; valid angles are 0..NUM_DEG-1.
- DEADBAND, 0, arrival tolerance in degrees, applied in both directions with wrap.
- DEAD_CYCLES, 1000, clocks with both motor outputs low between any direction change; also applied before the first drive from idle.
- STALL_CYCLES, 5000000, clocks of continuous drive with no change in filtered degree before a stall fault is raised.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- enc_degree  in  7  degree bus from the decoder; asynchronous to clk.
- target_deg  in  7  commanded angle.
- target_valid  in  1  one-cycle strobe that loads target_deg.
- enable  in  1  0 forces motor off and returns the controller to IDLE; the target is retained.
- fault_clear  in  1  pulse that leaves FAULT.
- turn_left  out  1  motor left (degree decreasing).
- turn_right  out  1  motor right (degree increasing).
- busy  out  1  high in DEAD and DRIVE.
- done  out  1  one-cycle pulse on arrival.
- at_target  out  1  level; filtered degree is within the deadband of the target.
- cmd_error  out  1  one-cycle pulse when an out-of-range target is rejected.
- fault  out  1  high in FAULT.
- cur_deg  out  7  filtered current degree.

Behaviour:
- Reset values:
  - All outputs 0.
  - cur_deg=0, target=0, state IDLE.
  - Stall and dead-time counters 0, last_dir=none.
- Input filtering:
  - enc_degree passes through a 2-flop synchroniser.
  - cur_deg updates only when two consecutive synchronised samples are equal and <NUM_DEG.
  - Otherwise cur_deg holds its value.
  - Latency from a stable bus change to cur_deg is 3 clk.
- Target load:
  - target_valid with target_deg<NUM_DEG loads the target, in any state except FAULT.
  - If target_deg>=NUM_DEG, the target is unchanged and cmd_error pulses the next cycle.
  - target_valid is ignored in FAULT (no cmd_error).
- Error computation:
  - diff=(target-cur_deg) mod NUM_DEG, range 0..89.
  - Arrived if diff<=DEADBAND or diff>=NUM_DEG-DEADBAND.
  - Otherwise want_dir=RIGHT if diff<=NUM_DEG/2 (tie at 45 goes RIGHT), else LEFT.
  - at_target is combinational from this comparison, registered one cycle.
- State IDLE:
  - Outputs off.
  - If enable and not arrived, go to DEAD with pending_dir=want_dir.
- State DEAD:
  - Outputs off; counter counts to DEAD_CYCLES-1, then go to DRIVE in pending_dir.
  - If want_dir changes during DEAD, pending_dir updates and the counter restarts.
  - If arrived during DEAD, go to IDLE and pulse done.
- State DRIVE:
  - Exactly one of turn_left/turn_right is high, per last_dir.
  - If arrived, outputs drop the same cycle the state leaves DRIVE; go to IDLE and pulse done.
  - If want_dir differs from last_dir (overshoot or new target), go to DEAD. Both outputs are never high, and no reversal happens without DEAD_CYCLES of off time.
  - The stall counter resets on every cur_deg change. When it reaches STALL_CYCLES, go to FAULT.
- State FAULT:
  - Outputs off, fault=1.
  - fault_clear returns to IDLE, clears the stall counter and sets last_dir=none.
- enable=0:
  - From DEAD or DRIVE, go to IDLE immediately, with no done pulse.
  - enable=0 does not exit FAULT.
- Simultaneous events:
  - Stall timeout and target_valid in the same cycle: FAULT wins and the target is dropped.
  - Stall timeout and arrival in the same cycle: arrival wins.
  - fault_clear and target_valid in the same cycle: clear wins and the target is dropped.
- Reset mid-operation: motor outputs drop asynchronously on reset assertion.

Test Plan:
- Right move: reset, enable=1, enc=10, load target 20 with DEAD_CYCLES=4 -> turn_right rises 4 clk after leaving IDLE. Step enc 11..20 -> turn_right falls and done pulses once when cur_deg=20.
- Wrap shortest path: cur=85, target=3 -> turn_right. Target 80 from cur=5 -> turn_left. Tie: cur=0, target=45 -> turn_right.
- Reversal: driving right toward 30, reload target 10 at cur=20 -> both outputs low for exactly DEAD_CYCLES, then turn_left. The two outputs are never high together (assertion checked every cycle).
- Stall: STALL_CYCLES=50, drive with enc frozen -> fault=1 at cycle 50, outputs off, target_valid ignored. fault_clear -> IDLE, then a new drive starts.
- Range/glitch: target 95 -> cmd_error pulse, target unchanged. A one-cycle glitch value 127 on enc -> cur_deg unchanged. DEADBAND=1, cur=89, target=0 -> at_target=1, no drive.
- Async reset mid-drive -> turn_right low within the reset assertion cycle, all outputs at reset values, and no drive after release until a new target or error.
